leglite_fetch_stage: RTL and testbench
======================================

Name: leglite_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined LEGLite core. It owns the program counter and drives the instruction-memory address. Each cycle it captures the returned 16-bit instruction word into the IF/ID register for the decode stage. It honours stall, flush and branch-redirect requests from later stages, and stops fetching at a halt instruction.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, PC increment per sequential fetch (byte addressing)
NOP_INSTR, 16'h0000, instruction word placed in IF/ID as a bubble
HALT_INSTR, 16'hFFFF, instruction word that puts the stage into HALT

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset; the stage is in reset while reset==0
idata  in  16  instruction memory read data for the current iaddr (combinational IM)
stall  in  1  hazard unit request to hold PC and IF/ID
flush  in  1  request to replace the IF/ID contents with a bubble
branch_taken  in  1  redirect request from the branch-resolving stage
branch_target  in  16  new PC, valid when branch_taken==1
iaddr  out  16  current PC, driven to instruction memory
ifid_instr  out  16  IF/ID instruction register
ifid_pc  out  16  PC of the instruction held in ifid_instr
ifid_valid  out  1  ifid_instr holds a real instruction, not a bubble
halted  out  1  1 while in HALT
fetch_count  out  16  number of instructions accepted into IF/ID

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, halted=0, fetch_count=0, state=BOOT.
- iaddr=pc, combinationally. The instruction for pc is captured at the same rising edge, so latency is 1 cycle from iaddr to ifid_instr.
- States:
  - BOOT: lasts one cycle after reset release. IF/ID stays a bubble and pc stays RESET_PC. Next state is RUN.
  - RUN: normal fetching.
  - HALT: fetching has stopped at a halt instruction.
- RUN, per-edge priority (highest first):
  1. branch_taken: pc<=branch_target; IF/ID<=bubble (NOP_INSTR, valid=0). Applies even when stall or flush is also asserted.
  2. stall (with or without flush): pc and IF/ID hold. flush is ignored while stall is high.
  3. flush: IF/ID<=bubble; pc<=pc+PC_STEP. The word at the old pc is discarded.
  4. Otherwise: ifid_instr<=idata, ifid_pc<=pc, ifid_valid<=1, pc<=pc+PC_STEP, fetch_count<=fetch_count+1.
- Halt detection: in case 4, if idata==HALT_INSTR, the word is accepted into IF/ID as valid and counted, pc holds (no increment), and the next state is HALT.
- HALT:
  - halted=1; pc holds.
  - IF/ID becomes a bubble on the edge after entry and stays a bubble.
  - stall and flush have no further effect on pc.
  - branch_taken leaves HALT: pc<=branch_target, IF/ID<=bubble, next state RUN, halted<=0.
- bubble means ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=pc at the time of insertion.
- Arithmetic: pc and fetch_count are 16-bit and wrap modulo 2^16 (16'hFFFE+2 -> 16'h0000; count 16'hFFFF+1 -> 0). No saturation.
- branch_target is used as given; no alignment check.
- In BOOT, stall, flush and branch_taken are ignored.
- Reset mid-operation, from any state: all registers return to reset values immediately, without waiting for a clock edge. Fetching restarts through BOOT.

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles, release; IM word0=16'h1234, word at 2=16'h5678 -> iaddr=0 during BOOT; one edge later ifid_instr=1234, ifid_pc=0, valid=1; next edge ifid_instr=5678, ifid_pc=2, fetch_count=2.
- Stall: assert stall for 3 cycles while pc=4 -> iaddr stays 4, IF/ID unchanged, fetch_count unchanged; after release the next edge loads the word at 4.
- Branch vs stall: at pc=8, assert stall=1, branch_taken=1, branch_target=16'h0040 together -> next edge iaddr=0x0040, ifid_valid=0, ifid_instr=0000; the following edge loads the word at 0x40, ifid_pc=0x40.
- Flush: at pc=6, flush=1 for 1 cycle -> ifid_valid=0, iaddr=8, fetch_count unchanged.
- Halt: word at 0x0A=16'hFFFF -> ifid_instr=FFFF valid=1, halted=1, iaddr stays 0x0A; the next edge gives a bubble; branch_taken to 0 resumes with halted=0.
- Async reset mid-run and wrap: branch to 16'hFFFE, fetch twice -> iaddr goes FFFE then 0000. Drop reset between clock edges -> outputs go to reset values before the next edge.

Source files
------------

// File: rtl/leglite_fetch_stage.sv
// LEGLite instruction-fetch stage: owns the PC, drives instruction memory and
// holds the IF/ID pipeline register, honouring stall, flush, redirect and halt.
module leglite_fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          PC_STEP    = 2,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] idata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] iaddr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 16'h0000;
      valid_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Redirect outranks stall and flush; stall outranks flush.
        if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = NOP_INSTR;
          ifpc_d  = pc_q;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (flush) begin
          pc_d    = pc_q + STEP;
          instr_d = NOP_INSTR;
          ifpc_d  = pc_q;
          valid_d = 1'b0;
        end else begin
          instr_d = idata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          count_d = count_q + 16'h0001;
          if (idata == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + STEP;
          end
        end
      end
      ST_HALT: begin
        instr_d = NOP_INSTR;
        ifpc_d  = pc_q;
        valid_d = 1'b0;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign iaddr       = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc     = ifpc_q;
  assign ifid_valid  = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_leglite_fetch_stage.sv
// Self-checking bench for leglite_fetch_stage: directed scenarios followed by
// randomized stall/flush/branch traffic against a behavioural fetch model.
module tb_leglite_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] idata;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] iaddr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:65535];

  // behavioural model of the architecturally visible state
  logic [15:0] m_pc, m_instr, m_ifpc, m_cnt;
  logic        m_valid, m_halted, m_booting;

  leglite_fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .idata         (idata),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .iaddr         (iaddr),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clock = ~clock;

  always_comb idata = mem[iaddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = 16'h0000;
    m_instr   = 16'h0000;
    m_ifpc    = 16'h0000;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_cnt     = 16'h0000;
    m_booting = 1'b1;
  endtask

  task automatic model_bubble();
    m_instr = 16'h0000;
    m_valid = 1'b0;
    m_ifpc  = m_pc;
  endtask

  // One rising edge of the model, from the inputs currently applied.
  task automatic model_edge();
    logic [15:0] w;
    if (!reset) begin
      model_reset();
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted) begin
      model_bubble();
      if (branch_taken) begin
        m_pc     = branch_target;
        m_halted = 1'b0;
      end
    end else if (branch_taken) begin
      model_bubble();
      m_pc = branch_target;
    end else if (stall) begin
      // everything holds
    end else if (flush) begin
      model_bubble();
      m_pc = m_pc + 16'd2;
    end else begin
      w       = mem[m_pc];
      m_instr = w;
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 16'd1;
      if (w == 16'hFFFF) m_halted = 1'b1;
      else               m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".iaddr"},  {16'h0, iaddr},       {16'h0, m_pc});
    chk({where, ".instr"},  {16'h0, ifid_instr},  {16'h0, m_instr});
    chk({where, ".valid"},  {31'h0, ifid_valid},  {31'h0, m_valid});
    chk({where, ".halted"}, {31'h0, halted},      {31'h0, m_halted});
    chk({where, ".count"},  {16'h0, fetch_count}, {16'h0, m_cnt});
    if (m_valid) chk({where, ".ifpc"}, {16'h0, ifid_pc}, {16'h0, m_ifpc});
  endtask

  // Inputs are applied at posedge+1; advance to the next edge and compare.
  task automatic step(input string where);
    model_edge();
    @(posedge clock);
    #1;
    check_all(where);
  endtask

  task automatic set_in(input logic s, input logic f, input logic b, input logic [15:0] t);
    stall = s; flush = f; branch_taken = b; branch_target = t;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++)
      mem[a] = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom);
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    mem[16'h0004] = 16'h1111;
    mem[16'h0006] = 16'h2222;
    mem[16'h0008] = 16'h3333;
    mem[16'h000A] = 16'hFFFF;
    mem[16'h0040] = 16'h4040;
    mem[16'hFFFE] = 16'hABCD;

    // reset held for two edges
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    check_all("reset");
    reset = 1'b1;

    step("boot");
    chk("boot.iaddr", {16'h0, iaddr}, 32'h0);
    step("fetch0");
    chk("fetch0.instr", {16'h0, ifid_instr}, 32'h1234);
    step("fetch2");
    chk("fetch2.instr", {16'h0, ifid_instr}, 32'h5678);
    chk("fetch2.count", {16'h0, fetch_count}, 32'h2);

    // stall three cycles at pc=4, with flush also raised in one of them
    set_in(1, 0, 0, 0); step("stall1");
    set_in(1, 1, 0, 0); step("stall2");
    set_in(1, 0, 0, 0); step("stall3");
    chk("stall.iaddr", {16'h0, iaddr}, 32'h4);
    set_in(0, 0, 0, 0); step("unstall");
    chk("unstall.instr", {16'h0, ifid_instr}, 32'h1111);

    set_in(0, 1, 0, 0); step("flush");
    chk("flush.iaddr", {16'h0, iaddr}, 32'h8);

    set_in(1, 1, 1, 16'h0040); step("brstall");
    chk("brstall.iaddr", {16'h0, iaddr}, 32'h40);
    set_in(0, 0, 0, 0); step("fetch40");
    chk("fetch40.ifpc", {16'h0, ifid_pc}, 32'h40);

    // halt at 0x0A
    set_in(0, 0, 1, 16'h000A); step("br0a");
    set_in(0, 0, 0, 0); step("halt");
    chk("halt.halted", {31'h0, halted}, 32'h1);
    chk("halt.iaddr", {16'h0, iaddr}, 32'hA);
    step("haltbub");
    set_in(1, 1, 0, 0); step("haltsf");
    set_in(0, 0, 1, 16'h0000); step("resume");
    chk("resume.halted", {31'h0, halted}, 32'h0);
    set_in(0, 0, 0, 0); step("refetch0");

    // pc wrap
    set_in(0, 0, 1, 16'hFFFE); step("brFFFE");
    set_in(0, 0, 0, 0); step("wrap");
    chk("wrap.iaddr", {16'h0, iaddr}, 32'h0);
    step("postwrap");

    // asynchronous reset between edges
    #3 reset = 1'b0;
    #1 model_reset();
    check_all("areset");
    @(posedge clock); #1;
    check_all("areset_hold");
    reset = 1'b1;
    step("boot2");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 9) == 0, {$urandom_range(0, 32767), 1'b0} );
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("rnd_areset");
        @(posedge clock); #1;
        reset = 1'b1;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
